// File: rtl/combo_lock_ctrl.sv
// Combination-lock controller: captures a nibble-at-a-time code, compares it with SECRET,
// counts wrong attempts and enforces a timed lockout. All outputs are registered.
module combo_lock_ctrl #(
  parameter int                      NUM_DIGITS     = 4,
  parameter logic [4*NUM_DIGITS-1:0] SECRET         = 16'h1234,
  parameter int                      MAX_TRIES      = 3,
  parameter int                      LOCKOUT_CYCLES = 250000000
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [3:0]                         sw_digit,
  input  logic                               btn_enter,
  input  logic                               btn_clear,
  input  logic                               btn_lock,
  output logic [4*NUM_DIGITS-1:0]            digits,
  output logic [NUM_DIGITS-1:0]              blank,
  output logic                               unlocked,
  output logic                               alarm,
  output logic [$clog2(MAX_TRIES+1)-1:0]     fail_count,
  output logic [1:0]                         o_dbg_state
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(NUM_DIGITS + 1);
  localparam int FW = $clog2(MAX_TRIES + 1);
  localparam int LW = $clog2(LOCKOUT_CYCLES);

  localparam logic [CW-1:0] FULL_CNT  = CW'(NUM_DIGITS);
  localparam logic [CW-1:0] ONE_CNT   = CW'(1);
  localparam logic [FW-1:0] MAX_FAIL  = FW'(MAX_TRIES);
  localparam logic [FW-1:0] ONE_FAIL  = FW'(1);
  localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_CYCLES - 1);
  localparam logic [LW-1:0] ONE_LOCK  = LW'(1);

  typedef enum logic [1:0] {
    ST_ENTRY   = 2'd0,
    ST_CHECK   = 2'd1,
    ST_OPEN    = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_e;

  // Button conditioning, bit 0 = enter, bit 1 = clear, bit 2 = lock.
  // Press pulse is registered so an action lands three edges after first sampling.
  logic [2:0] w_btn;
  logic [2:0] r_sync1, r_sync2, r_prev, r_press;

  assign w_btn = {btn_lock, btn_clear, btn_enter};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
      r_press <= '0;
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_press <= r_sync2 & ~r_prev;
    end
  end

  logic w_enter, w_clear, w_lock;
  assign w_enter = r_press[0];
  assign w_clear = r_press[1];
  assign w_lock  = r_press[2];

  state_e            r_state, w_state;
  logic [DW-1:0]     r_digits, w_digits;
  logic [NUM_DIGITS-1:0] r_blank, w_blank;
  logic [CW-1:0]     r_count, w_count;
  logic [FW-1:0]     r_fail, w_fail;
  logic [LW-1:0]     r_lock_cnt, w_lock_cnt;
  logic              r_unlocked, w_unlocked;
  logic              r_alarm, w_alarm;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_ENTRY;
      r_digits   <= '0;
      r_blank    <= '1;
      r_count    <= '0;
      r_fail     <= '0;
      r_lock_cnt <= '0;
      r_unlocked <= 1'b0;
      r_alarm    <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_digits   <= w_digits;
      r_blank    <= w_blank;
      r_count    <= w_count;
      r_fail     <= w_fail;
      r_lock_cnt <= w_lock_cnt;
      r_unlocked <= w_unlocked;
      r_alarm    <= w_alarm;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_digits   = r_digits;
    w_blank    = r_blank;
    w_count    = r_count;
    w_fail     = r_fail;
    w_lock_cnt = r_lock_cnt;
    w_unlocked = r_unlocked;
    w_alarm    = r_alarm;
    case (r_state)
      ST_ENTRY: begin
        // A full entry moves on to CHECK; clear beats a simultaneous enter.
        if (r_count == FULL_CNT) begin
          w_state = ST_CHECK;
        end else if (w_clear) begin
          w_digits = '0;
          w_blank  = '1;
          w_count  = '0;
        end else if (w_enter) begin
          w_digits = {r_digits[DW-5:0], sw_digit};
          w_blank  = {r_blank[NUM_DIGITS-2:0], 1'b0};
          w_count  = r_count + ONE_CNT;
        end
      end
      ST_CHECK: begin
        if (r_digits == SECRET) begin
          w_state    = ST_OPEN;
          w_unlocked = 1'b1;
          w_fail     = '0;
        end else if (r_fail + ONE_FAIL == MAX_FAIL) begin
          w_state    = ST_LOCKOUT;
          w_fail     = MAX_FAIL;
          w_lock_cnt = LOCK_LOAD;
          w_alarm    = 1'b1;
          w_digits   = {NUM_DIGITS{4'hE}};
          w_blank    = '0;
        end else begin
          w_state  = ST_ENTRY;
          w_fail   = r_fail + ONE_FAIL;
          w_digits = '0;
          w_blank  = '1;
          w_count  = '0;
        end
      end
      ST_OPEN: begin
        if (w_lock) begin
          w_state    = ST_ENTRY;
          w_unlocked = 1'b0;
          w_digits   = '0;
          w_blank    = '1;
          w_count    = '0;
        end
      end
      ST_LOCKOUT: begin
        // Counter walks LOCKOUT_CYCLES-1 down to 0; exit happens on the edge after 0.
        if (r_lock_cnt == '0) begin
          w_state  = ST_ENTRY;
          w_alarm  = 1'b0;
          w_fail   = '0;
          w_digits = '0;
          w_blank  = '1;
          w_count  = '0;
        end else begin
          w_lock_cnt = r_lock_cnt - ONE_LOCK;
        end
      end
      default: begin
        w_state = ST_ENTRY;
      end
    endcase
  end

  assign digits      = r_digits;
  assign blank       = r_blank;
  assign unlocked    = r_unlocked;
  assign alarm       = r_alarm;
  assign fail_count  = r_fail;
  assign o_dbg_state = r_state;

endmodule
